// File: rtl/conv_64_33_16_8_core.sv
// rtl/conv_64_33_16_8_core.sv - streaming valid-mode 1-D convolution, 64-sample vectors, 33 fixed taps, 8 MAC lanes
// Define CONV_RELU_EN to clamp negative outputs to zero.
module conv_64_33_16_8_core #(
  parameter int N = 64,
  parameter int M = 33,
  parameter int T = 16,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] s_data_in_x,
  input  logic         s_valid_x,
  output logic         s_ready_x,
  output logic [T-1:0] m_data_out_y,
  output logic         m_valid_y,
  input  logic         m_ready_y
);

  localparam int L  = N - M + 1;
  localparam int G  = L / P;
  localparam int XW = $clog2(N);
  localparam int KW = $clog2(M);
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int OW = (P > 1) ? $clog2(P) : 1;

  localparam logic [1:0] S_LOAD    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  localparam logic [T-1:0] C_COEF [M] = '{
    16'h0003, 16'hFFFE, 16'h0105, 16'h7A31, 16'h8123, 16'h0042, 16'hFF80, 16'h1234,
    16'hEDCB, 16'h0007, 16'h4000, 16'hC001, 16'h0010, 16'hFFF0, 16'h2A2A, 16'hD5D5,
    16'h0001, 16'h7FFF, 16'h8000, 16'h0333, 16'hFCCD, 16'h0055, 16'hFFAB, 16'h3C3C,
    16'hC3C4, 16'h0009, 16'hFFF7, 16'h1111, 16'hEEEF, 16'h0100, 16'hFF00, 16'h5A5A,
    16'hA5A6
  };

  logic [1:0]    r_state;
  logic          r_run;
  logic [XW-1:0] r_in_cnt;
  logic [T-1:0]  r_x [N];
  logic [KW-1:0] r_k;
  logic [GW-1:0] r_grp;
  logic [OW-1:0] r_oidx;
  logic [T-1:0]  r_acc [P];

  logic [T-1:0]  w_coef;
  logic [XW-1:0] w_idx [P];
  logic [T-1:0]  w_prod [P];
  logic [T-1:0]  w_sel;
  logic [T-1:0]  w_y;
  logic          w_in_xfer;

  // r_run keeps s_ready_x low until the first edge after reset releases.
  assign s_ready_x    = r_run && (r_state == S_LOAD);
  assign m_valid_y    = (r_state == S_DRAIN);
  assign w_in_xfer    = s_valid_x && s_ready_x;
  assign m_data_out_y = m_valid_y ? w_y : '0;

  // Low T bits of a two's-complement product do not depend on operand signedness.
  always_comb begin
    w_coef = C_COEF[r_k];
    for (int p = 0; p < P; p++) begin
      w_idx[p]  = XW'(XW'(r_grp) * XW'(P) + XW'(p) + XW'(r_k));
      w_prod[p] = r_x[w_idx[p]] * w_coef;
    end
  end

  always_comb begin
    w_sel = r_acc[r_oidx];
`ifdef CONV_RELU_EN
    w_y = w_sel[T-1] ? '0 : w_sel;
`else
    w_y = w_sel;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_LOAD;
      r_run    <= 1'b0;
      r_in_cnt <= '0;
      r_k      <= '0;
      r_grp    <= '0;
      r_oidx   <= '0;
      for (int i = 0; i < N; i++) r_x[i] <= '0;
      for (int p = 0; p < P; p++) r_acc[p] <= '0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        S_LOAD: begin
          if (w_in_xfer) begin
            r_x[r_in_cnt] <= s_data_in_x;
            if (r_in_cnt == XW'(N - 1)) begin
              r_in_cnt <= '0;
              r_k      <= '0;
              r_grp    <= '0;
              r_state  <= S_COMPUTE;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          // Tap 0 overwrites, so lanes need no separate clear between groups.
          for (int p = 0; p < P; p++)
            r_acc[p] <= (r_k == '0) ? w_prod[p] : r_acc[p] + w_prod[p];
          if (r_k == KW'(M - 1)) begin
            r_k     <= '0;
            r_oidx  <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DRAIN: begin
          if (m_ready_y) begin
            if (r_oidx == OW'(P - 1)) begin
              r_oidx <= '0;
              if (r_grp == GW'(G - 1)) begin
                r_grp   <= '0;
                r_state <= S_LOAD;
              end else begin
                r_grp   <= r_grp + 1'b1;
                r_state <= S_COMPUTE;
              end
            end else begin
              r_oidx <= r_oidx + 1'b1;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_64_33_16_8_core.sv
// tb/tb_conv_64_33_16_8_core.sv - scoreboard bench for conv_64_33_16_8_core against a plain-arithmetic convolution model
`timescale 1ns/1ps
module tb_conv_64_33_16_8_core;

  localparam int N = 64;
  localparam int M = 33;
  localparam int L = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] s_data_in_x = '0;
  logic        s_valid_x = 1'b0;
  logic        s_ready_x;
  logic [15:0] m_data_out_y;
  logic        m_valid_y;
  logic        m_ready_y = 1'b0;

  always #5 clk = ~clk;

  conv_64_33_16_8_core dut (
    .clk          (clk),
    .reset        (reset),
    .s_data_in_x  (s_data_in_x),
    .s_valid_x    (s_valid_x),
    .s_ready_x    (s_ready_x),
    .m_data_out_y (m_data_out_y),
    .m_valid_y    (m_valid_y),
    .m_ready_y    (m_ready_y)
  );

  localparam logic [15:0] F [M] = '{
    16'h0003, 16'hFFFE, 16'h0105, 16'h7A31, 16'h8123, 16'h0042, 16'hFF80, 16'h1234,
    16'hEDCB, 16'h0007, 16'h4000, 16'hC001, 16'h0010, 16'hFFF0, 16'h2A2A, 16'hD5D5,
    16'h0001, 16'h7FFF, 16'h8000, 16'h0333, 16'hFCCD, 16'h0055, 16'hFFAB, 16'h3C3C,
    16'hC3C4, 16'h0009, 16'hFFF7, 16'h1111, 16'hEEEF, 16'h0100, 16'hFF00, 16'h5A5A,
    16'hA5A6
  };

  int          errors = 0;
  int          checks = 0;
  int          ready_mode = 0;
  int          out_count = 0;
  logic [15:0] exp_q [$];
  logic [15:0] vec [N];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic checki(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef CONV_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic model_push();
    logic [15:0] acc;
    int          prod;
    for (int i = 0; i < L; i++) begin
      acc = '0;
      for (int j = 0; j < M; j++) begin
        prod = $signed(vec[i+j]) * $signed(F[j]);
        acc  = acc + prod[15:0];
      end
      exp_q.push_back(relu(acc));
    end
  endtask

  task automatic send_sample(input logic [15:0] d, output bit ok);
    int   cyc;
    logic rdy;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 5000) begin
      @(negedge clk);
      s_valid_x   = ($urandom_range(3) != 0);
      s_data_in_x = s_valid_x ? d : 16'($urandom);
      rdy = s_ready_x;
      @(posedge clk);
      if (s_valid_x && rdy) ok = 1'b1;
      cyc++;
    end
  endtask

  task automatic send_vec(input bit use_model);
    int n;
    bit ok;
    n = 0;
    for (int i = 0; i < N; i++) begin
      send_sample(vec[i], ok);
      if (!ok) break;
      n++;
    end
    checki("vec_accept_count", n, N);
    if (n == N && use_model) model_push();
    #1 s_valid_x = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    checki(name, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check1("rst_s_ready", s_ready_x, 1'b0);
    check1("rst_m_valid", m_valid_y, 1'b0);
    check16("rst_m_data", m_data_out_y, 16'h0000);
    exp_q.delete();
    s_valid_x = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check1("post_rst_s_ready", s_ready_x, 1'b1);
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!m_valid_y && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin : monitor
    logic        pv, pr;
    logic [15:0] pd;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pv = 1'b0;
        m_ready_y = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        check1("stall_valid_hold", m_valid_y, 1'b1);
        check16("stall_data_hold", m_data_out_y, pd);
      end
      case (ready_mode)
        0:       m_ready_y = ($urandom_range(3) != 0);
        1:       m_ready_y = 1'b0;
        default: m_ready_y = 1'b1;
      endcase
      if (m_valid_y && m_ready_y) begin
        out_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", m_data_out_y);
        end else begin
          check16("y_data", m_data_out_y, exp_q.pop_front());
        end
      end
      pv = m_valid_y;
      pr = m_ready_y;
      pd = m_data_out_y;
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : stimulus
    int          cnt;
    int          out0;
    bit          ok;
    logic [15:0] first_d;

    do_reset();

    for (int i = 0; i < N; i++) vec[i] = '0;
    send_vec(1'b1);
    wait_empty("zero_vec_drain");

    for (int i = 0; i < N; i++) vec[i] = '0;
    vec[40] = 16'h0001;
    for (int i = 0; i < L; i++) exp_q.push_back(i < 8 ? 16'h0000 : relu(F[40-i]));
    send_vec(1'b0);
    wait_empty("impulse_drain");

    for (int i = 0; i < N; i++) vec[i] = 16'h7FFF;
    send_vec(1'b1);
    wait_empty("max_vec_drain");

    ready_mode = 1;
    for (int i = 0; i < N; i++) vec[i] = 16'($urandom);
    send_vec(1'b1);
    wait_valid(cnt);
    check1("first_valid_seen", m_valid_y, 1'b1);
    check1("first_valid_latency_ok", cnt <= M + 4, 1'b1);
    first_d = (exp_q.size() != 0) ? exp_q[0] : 16'h0000;
    repeat (100) begin
      @(negedge clk);
      check1("hold_s_ready", s_ready_x, 1'b0);
      check1("hold_m_valid", m_valid_y, 1'b1);
      check16("hold_m_data", m_data_out_y, first_d);
    end
    ready_mode = 0;
    wait_empty("hold_drain");

    ready_mode = 1;
    for (int i = 0; i < N; i++) vec[i] = 16'($urandom);
    send_vec(1'b0);
    wait_valid(cnt);
    check1("drain_valid_before_reset", m_valid_y, 1'b1);
    do_reset();
    ready_mode = 0;

    for (int i = 0; i < 30; i++) begin
      send_sample(16'($urandom), ok);
      check1("partial_accept", ok, 1'b1);
    end
    do_reset();
    for (int i = 0; i < N; i++) vec[i] = 16'($urandom);
    send_vec(1'b1);
    wait_empty("after_reset_drain");

    out0 = out_count;
    for (int v = 0; v < 156; v++) begin
      for (int i = 0; i < N; i++) vec[i] = 16'($urandom);
      send_vec(1'b1);
    end
    wait_empty("random_drain");
    checki("random_out_count", out_count - out0, 4992);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_64_33_16_8_core.md
CONV_64_33_16_8_CORE -- requirements
Module: conv_64_33_16_8

Interface
REQ-001 SHALL: parameter N, 64, input vector length.
REQ-002 SHALL: parameter M, 33, filter length; output vector length is N-M+1 = 32.
REQ-003 SHALL: parameter T, 16, data/coefficient width in bits, signed two's complement.
REQ-004 SHALL: parameter P, 8, number of parallel multiply-accumulate lanes; P divides N-M+1.
REQ-005 SHALL: clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL: reset  input  1  reset is asynchronous and active-low.
REQ-007 SHALL: s_data_in_x  input  T  input sample x, signed.
REQ-008 SHALL: s_valid_x  input  1  input sample valid.
REQ-009 SHALL: s_ready_x  output  1  block can accept an input sample.
REQ-010 SHALL: m_data_out_y  output  T  output sample y, signed.
REQ-011 SHALL: m_valid_y  output  1  output sample valid.
REQ-012 SHALL: m_ready_y  input  1  downstream accepts the output sample.
REQ-013 SHALL: port order is clk, reset, s_data_in_x, s_valid_x, s_ready_x, m_data_out_y, m_valid_y, m_ready_y.

Function
REQ-014 SHALL: for each consecutive group of N accepted inputs x[0..63], produce y[i] = sum over j=0..M-1 of x[i+j]*f[j] for i=0..31, emitted in ascending order of i.
REQ-015 SHALL: coefficients f[0..32] are fixed, held in an internal read-only table of M signed T-bit words; there is no coefficient load port.
REQ-016 SHALL: each product is truncated to its low T bits; accumulation is T-bit wrap-around (modulo 2^T).
REQ-017 SHALL: an input transfer occurs on a rising edge with s_valid_x=1 and s_ready_x=1; an output transfer occurs on a rising edge with m_valid_y=1 and m_ready_y=1.
REQ-018 SHALL: s_ready_x is 1 while the input buffer holds fewer than N samples of the current vector, and is 0 from the edge after the Nth accept until the 32nd output of that vector has transferred.
REQ-019 SHALL: while m_valid_y=1 and m_ready_y=0, m_data_out_y and m_valid_y hold unchanged.
REQ-020 SHALL: the FSM has states LOAD, COMPUTE and DRAIN.
REQ-021 SHALL: in LOAD, the FSM goes to COMPUTE after the Nth accept.
REQ-022 SHALL: COMPUTE computes P outputs in parallel over M cycles into a P-entry output buffer, then goes to DRAIN.
REQ-023 SHALL: DRAIN goes to COMPUTE for the next P outputs when the buffer empties, or to LOAD after the 4th group.
REQ-024 SHALL: the first m_valid_y asserts no more than M+4 cycles after the Nth input accept.
REQ-025 SHALL: s_valid_x while s_ready_x=0 is ignored, and m_ready_y while m_valid_y=0 is ignored.
REQ-026 SHALL: vectors are processed back-to-back indefinitely, with no gap state or count limit.

Reset
REQ-027 SHALL: asserting reset at any time, including mid-vector, asynchronously drives s_ready_x=0, m_valid_y=0, m_data_out_y=0, clears all counters and buffers, and puts the FSM in LOAD.
REQ-028 SHALL: after reset releases, s_ready_x=1 from the first rising edge, and the next accepted sample is x[0] of a new vector.

Configuration
REQ-029 SHALL: macro CONV_RELU_EN, when defined, makes each output y[i] = max(0, sum).
REQ-030 SHALL: without CONV_RELU_EN, the raw wrapped sum is output; production builds define CONV_RELU_EN.

Verification
REQ-031 SHALL: 156 vectors (9984 inputs) with random s_valid_x/m_ready_y each cycle -> exactly 4992 outputs, all bit-exact to the software model.
REQ-032 SHALL: all-zero vector -> 32 outputs of 0x0000.
REQ-033 SHALL: impulse x[k]=1 (k=40), others 0, ReLU off -> y[i]=f[40-i] for 8<=i<=31, and y[i]=0 for i<8.
REQ-034 SHALL: m_ready_y held 0 for 100 cycles after the first m_valid_y -> output held stable, s_ready_x stays 0, no output lost.
REQ-035 SHALL: reset asserted after 30 inputs of a vector, then a full vector applied -> outputs correspond only to the new vector.
REQ-036 SHALL: x all 0x7FFF with large coefficients -> wrap-around sum matches the modulo-2^16 model, and ReLU clamps negatives to 0.
